// File: rtl/clk_rst_ctrl.sv
// -----------------------------------------------------------------------------
// clk_rst_ctrl
//
// Clock/reset controller that sits directly behind the PLL and runs on its
// output clock. It qualifies the PLL lock indication, holds the CPU in a
// synchronous reset until the lock has been stable for LOCK_CYCLES cycles,
// and then drives run / halt / single-step control of the pipeline through a
// clock-enable. A peripheral tick is derived by dividing the enabled cycles
// by DIV. No clock is gated: every consumer runs on clk and uses cpu_rst,
// cpu_en and periph_tick as qualifiers.
//
// Parameters:
//   LOCK_CYCLES  consecutive synchronized-lock cycles before reset release (>=1)
//   DIV          period of periph_tick in enabled cycles (>=1)
//
// Ports:
//   clk          in   PLL output clock, sole clock of the block
//   rst          in   asynchronous active-high reset
//   pll_locked   in   PLL lock indicator, asynchronous to clk
//   halt_req     in   level, 1 = pause the pipeline
//   step_req     in   level, each rising edge requests one enabled cycle
//                     while halted (synchronous to clk)
//   cpu_rst      out  synchronous active-high CPU reset (registered)
//   cpu_en       out  pipeline clock-enable (registered)
//   periph_tick  out  one-cycle strobe every DIV enabled cycles (registered)
//   state        out  FSM state: WAIT=0, RUN=1, HALT=2, STEP=3 (registered)
// -----------------------------------------------------------------------------
module clk_rst_ctrl #(
    parameter int LOCK_CYCLES = 16,
    parameter int DIV         = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       halt_req,
    input  logic       step_req,
    output logic       cpu_rst,
    output logic       cpu_en,
    output logic       periph_tick,
    output logic [1:0] state
);

    // Counter widths: $clog2 of the parameter, never narrower than one bit.
    localparam int LCW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam int DVW = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_CYCLES - 1);
    localparam logic [DVW-1:0] DIV_LAST  = DVW'(DIV - 1);
    localparam logic [LCW-1:0] LOCK_ZERO = {LCW{1'b0}};
    localparam logic [DVW-1:0] DIV_ZERO  = {DVW{1'b0}};

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2,
        ST_STEP = 2'd3
    } state_t;

    // Divider advance: returns {tick, next_count}. The divider only moves on
    // enabled cycles, so the tick phase survives halt and single-step.
    function automatic logic [DVW:0] div_advance(input logic [DVW-1:0] cnt,
                                                  input logic           en);
        logic [DVW:0] res;
        if (!en) begin
            res = {1'b0, cnt};
        end else if (cnt == DIV_LAST) begin
            res = {1'b1, DIV_ZERO};
        end else begin
            res = {1'b0, cnt + DVW'(1)};
        end
        return res;
    endfunction

    // Synchronizer and step-edge registers
    logic           sync1_r;
    logic           sync2_r;
    logic           lock_s;
    logic           step_q_r;
    logic           step_edge_s;

    // FSM, output and counter registers with their next-state values
    state_t         state_r;
    state_t         state_nxt_s;
    logic           cpu_rst_r;
    logic           cpu_rst_nxt_s;
    logic           cpu_en_r;
    logic           cpu_en_nxt_s;
    logic           tick_r;
    logic           tick_nxt_s;
    logic [LCW-1:0] lock_cnt_r;
    logic [LCW-1:0] lock_cnt_nxt_s;
    logic [DVW-1:0] div_r;
    logic [DVW-1:0] div_nxt_s;

    assign lock_s      = sync2_r;
    assign step_edge_s = step_req & ~step_q_r;

    // Two-flop synchronizer bringing pll_locked into the clk domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= pll_locked;
            sync2_r <= sync1_r;
        end
    end

    // Previous step_req, used to turn the level into a rising-edge request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_q_r <= 1'b0;
        end else begin
            step_q_r <= step_req;
        end
    end

    // State, registered outputs, lock counter and divider.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_WAIT;
            cpu_rst_r  <= 1'b1;
            cpu_en_r   <= 1'b0;
            tick_r     <= 1'b0;
            lock_cnt_r <= LOCK_ZERO;
            div_r      <= DIV_ZERO;
        end else begin
            state_r    <= state_nxt_s;
            cpu_rst_r  <= cpu_rst_nxt_s;
            cpu_en_r   <= cpu_en_nxt_s;
            tick_r     <= tick_nxt_s;
            lock_cnt_r <= lock_cnt_nxt_s;
            div_r      <= div_nxt_s;
        end
    end

    // Next-state and next-output logic. Loss of lock outranks halt_req,
    // which outranks a step edge. Step edges seen outside HALT are simply
    // ignored, so a step that coincides with a halt in RUN is consumed.
    always_comb begin
        state_nxt_s                = state_r;
        cpu_rst_nxt_s              = cpu_rst_r;
        cpu_en_nxt_s               = cpu_en_r;
        lock_cnt_nxt_s             = lock_cnt_r;
        {tick_nxt_s, div_nxt_s}    = div_advance(div_r, cpu_en_r);

        if ((state_r != ST_WAIT) && !lock_s) begin
            // Lock lost while operating: back to reset, full re-qualification.
            state_nxt_s    = ST_WAIT;
            cpu_rst_nxt_s  = 1'b1;
            cpu_en_nxt_s   = 1'b0;
            lock_cnt_nxt_s = LOCK_ZERO;
            div_nxt_s      = DIV_ZERO;
            tick_nxt_s     = 1'b0;
        end else begin
            case (state_r)
                ST_WAIT: begin
                    cpu_rst_nxt_s = 1'b1;
                    cpu_en_nxt_s  = 1'b0;
                    div_nxt_s     = DIV_ZERO;
                    tick_nxt_s    = 1'b0;
                    if (lock_s) begin
                        if (lock_cnt_r == LOCK_LAST) begin
                            // Counter stops here; it never wraps past the limit.
                            state_nxt_s    = ST_RUN;
                            cpu_rst_nxt_s  = 1'b0;
                            cpu_en_nxt_s   = 1'b1;
                            lock_cnt_nxt_s = LOCK_ZERO;
                        end else begin
                            lock_cnt_nxt_s = lock_cnt_r + LCW'(1);
                        end
                    end else begin
                        lock_cnt_nxt_s = LOCK_ZERO;
                    end
                end
                ST_RUN: begin
                    cpu_rst_nxt_s = 1'b0;
                    if (halt_req) begin
                        state_nxt_s  = ST_HALT;
                        cpu_en_nxt_s = 1'b0;
                    end else begin
                        state_nxt_s  = ST_RUN;
                        cpu_en_nxt_s = 1'b1;
                    end
                end
                ST_HALT: begin
                    cpu_rst_nxt_s = 1'b0;
                    if (!halt_req) begin
                        state_nxt_s  = ST_RUN;
                        cpu_en_nxt_s = 1'b1;
                    end else if (step_edge_s) begin
                        state_nxt_s  = ST_STEP;
                        cpu_en_nxt_s = 1'b1;
                    end else begin
                        state_nxt_s  = ST_HALT;
                        cpu_en_nxt_s = 1'b0;
                    end
                end
                ST_STEP: begin
                    // Exactly one enabled cycle, then follow halt_req.
                    cpu_rst_nxt_s = 1'b0;
                    if (halt_req) begin
                        state_nxt_s  = ST_HALT;
                        cpu_en_nxt_s = 1'b0;
                    end else begin
                        state_nxt_s  = ST_RUN;
                        cpu_en_nxt_s = 1'b1;
                    end
                end
                default: begin
                    // Unreachable encoding: fall back to the safe reset state.
                    state_nxt_s    = ST_WAIT;
                    cpu_rst_nxt_s  = 1'b1;
                    cpu_en_nxt_s   = 1'b0;
                    lock_cnt_nxt_s = LOCK_ZERO;
                    div_nxt_s      = DIV_ZERO;
                    tick_nxt_s     = 1'b0;
                end
            endcase
        end
    end

    assign cpu_rst     = cpu_rst_r;
    assign cpu_en      = cpu_en_r;
    assign periph_tick = tick_r;
    assign state       = state_r;

endmodule
